// File: rtl/aes_cbc_axis_framer_pkg.sv
// Shared AES sizes and framer-wide types for the CBC AXI-Stream framer.
// The one-hot state constants live in the top module; only their width is shared here.
package aes_cbc_axis_framer_pkg;

    localparam int AES_BLOCK_SIZE     = 128;
    localparam int AES_256_KEY_LENGTH = 256;
    localparam int STATE_W            = 6;

    typedef logic [STATE_W-1:0] state_t;

    function automatic int beats_per_unit(input int w);
        return AES_BLOCK_SIZE / w;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle carrying beats from the framer to the cipher core's slave port.
interface axis_if #(
    parameter int W = 8
);
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tvalid;
    logic           tready;
    logic           tlast;
    logic           tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/aes_axis_serializer.sv
// Slices a 128-bit unit into W-bit beats, least significant beat first.
// The beat counter only moves on a handshake and wraps after the last beat of a unit.
module aes_axis_serializer
    import aes_cbc_axis_framer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AES_BLOCK_SIZE-1:0] src,
    input  logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [W-1:0]              beat_data,
    output logic                      final_beat,
    output logic                      beat_fire
);
    localparam int N  = beats_per_unit(W);
    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt_q, cnt_d;

    assign beat_fire  = beat_valid & beat_ready;
    assign final_beat = (cnt_q == CW'(N - 1));
    assign beat_data  = src[int'(cnt_q) * W +: W];

    always_comb begin
        cnt_d = cnt_q;
        if (beat_fire) begin
            cnt_d = final_beat ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_cbc_axis_framer.sv
// Session framer: streams key_lo, key_hi and IV, then each text block, to the cipher core.
// A stall (tvalid without tready) leaves every register untouched, so beats are held stable.
module aes_cbc_axis_framer
    import aes_cbc_axis_framer_pkg::*;
#(
    parameter int M_AXIS_WIDTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Cmd_valid,
    output logic                          Cmd_ready,
    input  logic [AES_256_KEY_LENGTH-1:0] Cmd_key,
    input  logic [AES_BLOCK_SIZE-1:0]     Cmd_iv,
    input  logic                          Cmd_enc,
    input  logic                          Blk_valid,
    output logic                          Blk_ready,
    input  logic [AES_BLOCK_SIZE-1:0]     Blk_data,
    input  logic                          Blk_last,
    axis_if.master                        M_axis,
    output logic                          Busy
);
    localparam state_t ST_IDLE     = 6'b000001;
    localparam state_t ST_KEY_0    = 6'b000010;
    localparam state_t ST_KEY_1    = 6'b000100;
    localparam state_t ST_IV       = 6'b001000;
    localparam state_t ST_BLK_WAIT = 6'b010000;
    localparam state_t ST_TEXT     = 6'b100000;
    localparam state_t STREAMING   = ST_KEY_0 | ST_KEY_1 | ST_IV | ST_TEXT;

    state_t                          state_q, state_d;
    logic [AES_256_KEY_LENGTH-1:0]   key_q, key_d;
    logic [AES_BLOCK_SIZE-1:0]       iv_q, iv_d;
    logic [AES_BLOCK_SIZE-1:0]       blk_q, blk_d;
    logic                            enc_q, enc_d;
    logic                            last_q, last_d;

    logic [AES_BLOCK_SIZE-1:0]       src;
    logic [M_AXIS_WIDTH-1:0]         beat_data;
    logic                            tvalid;
    logic                            final_beat;
    logic                            beat_fire;

    assign tvalid    = (state_q & STREAMING) != '0;
    assign Cmd_ready = (state_q == ST_IDLE);
    assign Blk_ready = (state_q == ST_BLK_WAIT);
    assign Busy      = (state_q != ST_IDLE);

    always_comb begin
        src = '0;
        case (state_q)
            ST_KEY_0: src = key_q[127:0];
            ST_KEY_1: src = key_q[255:128];
            ST_IV:    src = iv_q;
            ST_TEXT:  src = blk_q;
            default:  src = '0;
        endcase
    end

    aes_axis_serializer #(.W(M_AXIS_WIDTH)) u_serializer (
        .clk        (Clk),
        .rst_n      (Rst),
        .src        (src),
        .beat_valid (tvalid),
        .beat_ready (M_axis.tready),
        .beat_data  (beat_data),
        .final_beat (final_beat),
        .beat_fire  (beat_fire)
    );

    assign M_axis.tvalid = tvalid;
    assign M_axis.tdata  = tvalid ? beat_data : '0;
    assign M_axis.tkeep  = {(M_AXIS_WIDTH/8){tvalid}};
    assign M_axis.tuser  = enc_q & tvalid;
    assign M_axis.tlast  = tvalid & (state_q == ST_TEXT) & last_q & final_beat;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        iv_d    = iv_q;
        blk_d   = blk_q;
        enc_d   = enc_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (Cmd_valid) begin
                    key_d   = Cmd_key;
                    iv_d    = Cmd_iv;
                    enc_d   = Cmd_enc;
                    state_d = ST_KEY_0;
                end
            end
            ST_KEY_0:    if (beat_fire && final_beat) state_d = ST_KEY_1;
            ST_KEY_1:    if (beat_fire && final_beat) state_d = ST_IV;
            ST_IV:       if (beat_fire && final_beat) state_d = ST_BLK_WAIT;
            ST_BLK_WAIT: begin
                if (Blk_valid) begin
                    blk_d   = Blk_data;
                    last_d  = Blk_last;
                    state_d = ST_TEXT;
                end
            end
            ST_TEXT: begin
                if (beat_fire && final_beat) begin
                    state_d = last_q ? ST_IDLE : ST_BLK_WAIT;
                end
            end
            // Any non-one-hot value falls back to idle rather than locking up.
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            iv_q    <= '0;
            blk_q   <= '0;
            enc_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            blk_q   <= blk_d;
            enc_q   <= enc_d;
            last_q  <= last_d;
        end
    end

endmodule
